// File: rtl/data_memory_param_if.sv
// Request/response bus between a requester and the parametrised data memory.
interface data_memory_param_if #(
   parameter int unsigned LINE_BITS = 256,
   parameter int unsigned ADDR_BITS = 32
);
   localparam int unsigned LINE_BYTES = LINE_BITS / 8;

   logic [ADDR_BITS-1:0]  addr_i;
   logic [LINE_BITS-1:0]  data_i;
   logic [LINE_BYTES-1:0] mask_i;
   logic                  enable_i;
   logic                  write_i;
   logic                  ack_o;
   logic                  err_o;
   logic                  busy_o;
   logic [LINE_BITS-1:0]  data_o;

   // Requester side
   modport master (
      output addr_i, data_i, mask_i, enable_i, write_i,
      input  ack_o, err_o, busy_o, data_o
   );

   // Memory side
   modport slave (
      input  addr_i, data_i, mask_i, enable_i, write_i,
      output ack_o, err_o, busy_o, data_o
   );
endinterface

// File: rtl/data_memory_param.sv
// Parametrised line-wide backing memory with fixed access latency,
// per-byte write mask and out-of-range error response.
module data_memory_param #(
   parameter int unsigned LINE_BITS = 256,
   parameter int unsigned DEPTH     = 512,
   parameter int unsigned LATENCY   = 10,
   parameter int unsigned ADDR_BITS = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   data_memory_param_if.slave  bus
);
   localparam int unsigned LINE_BYTES    = LINE_BITS / 8;
   localparam int unsigned OFFSET_BITS   = $clog2(LINE_BYTES);
   localparam int unsigned IDX_BITS      = $clog2(DEPTH);
   localparam int unsigned FULL_IDX_BITS = ADDR_BITS - OFFSET_BITS;
   localparam int unsigned CNT_BITS      = $clog2(LATENCY + 1);

   typedef struct packed {
      logic [FULL_IDX_BITS-1:0] idx;
      logic [LINE_BITS-1:0]     data;
      logic [LINE_BYTES-1:0]    mask;
      logic                     write;
   } req_t;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t                state_q, state_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;
   req_t                  req_q, req_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic                  busy_q, busy_d;
   logic [LINE_BITS-1:0]  data_q, data_d;
   logic                  mem_we;
   logic                  in_range;
   logic [LINE_BITS-1:0]  cur_line;
   logic [LINE_BITS-1:0]  merged;
   logic                  unused_addr_bits;

   logic [LINE_BITS-1:0]  mem [DEPTH];

   // Byte offset within a line does not select anything
   assign unused_addr_bits = ^bus.addr_i[OFFSET_BITS-1:0];

   // Full shifted index is compared so high address bits never alias
   assign in_range = (req_q.idx < FULL_IDX_BITS'(DEPTH));
   assign cur_line = mem[req_q.idx[IDX_BITS-1:0]];

   // Merge captured write data into the current line under the byte mask
   always_comb begin
      merged = cur_line;
      for (int unsigned k = 0; k < LINE_BYTES; k++) begin
         if (req_q.mask[k]) merged[8*k +: 8] = req_q.data[8*k +: 8];
      end
   end

   // Next-state and output logic; counter holds edges elapsed since acceptance
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      data_d  = data_q;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.enable_i) begin
               req_d.idx   = bus.addr_i[ADDR_BITS-1:OFFSET_BITS];
               req_d.data  = bus.data_i;
               req_d.mask  = bus.mask_i;
               req_d.write = bus.write_i;
               cnt_d       = CNT_BITS'(1);
               state_d     = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_BITS'(1);
            if (cnt_q == CNT_BITS'(LATENCY)) begin
               ack_d   = 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
               if (!in_range) begin
                  err_d  = 1'b1;
                  data_d = '0;
               end else if (req_q.write) begin
                  mem_we = 1'b1;
                  data_d = merged;
               end else begin
                  data_d = cur_line;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == WAIT);
   end

   // Control and response registers with synchronous active-low reset
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         data_q  <= data_d;
      end
   end

   // Captured request fields need no reset
   always_ff @(posedge clk_i) begin
      req_q <= req_d;
   end

   // Array write; a reset on the completion edge suppresses it
   always_ff @(posedge clk_i) begin
      if (mem_we && rst_i) mem[req_q.idx[IDX_BITS-1:0]] <= merged;
   end

   assign bus.ack_o  = ack_q;
   assign bus.err_o  = err_q;
   assign bus.busy_o = busy_q;
   assign bus.data_o = data_q;
endmodule
